// File: rtl/prog_feeder.sv
// prog_feeder: small program store that feeds instruction words to a processor one at a time
// using a Run/Done handshake, with acknowledge and completion timeouts.
//
// Ports:
//   Clock    - rising-edge clock
//   Resetn   - synchronous active-low reset (program memory is not cleared)
//   WrEn     - program write strobe (ignored while Busy)
//   WrAddr   - program write address
//   WrData   - program write word
//   Start    - begin execution at address 0 (accepted only in idle with Done high)
//   Done     - processor completion flag, high when the processor is idle
//   DIN      - word presented to the processor
//   Run      - one-cycle issue pulse
//   Busy     - program executing
//   Finished - program ended normally (sticky until next accepted Start)
//   Error    - handshake timeout (sticky until next accepted Start)
//   PC       - address of the current instruction
module prog_feeder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned ACK_TO  = 4,
  parameter int unsigned DONE_TO = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       WrEn,
  input  logic [4:0] WrAddr,
  input  logic [8:0] WrData,
  input  logic       Start,
  input  logic       Done,
  output logic [8:0] DIN,
  output logic       Run,
  output logic       Busy,
  output logic       Finished,
  output logic       Error,
  output logic [4:0] PC
);

  localparam logic [2:0] OpMvi  = 3'b001;
  localparam logic [2:0] OpHalt = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAck,
    StWaitDone,
    StAdvance,
    StHalted,
    StErr
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] pc_q, pc_d;
  logic [8:0] din_q, din_d;
  logic       run_q, run_d;
  logic       busy_q, busy_d;
  logic       fin_q, fin_d;
  logic       err_q, err_d;
  logic [3:0] cnt_q, cnt_d;

  logic [8:0] mem [DEPTH];

  logic [8:0] cur_word;
  logic       cur_mvi;
  logic [4:0] imm_addr;
  logic [8:0] operand;
  logic [5:0] pc_sum;
  logic       pc_wrap;
  logic [8:0] next_word;

  // Program store: no reset, writes locked out while a program runs.
  always_ff @(posedge Clock) begin
    if (WrEn && !busy_q) begin
      mem[WrAddr] <= WrData;
    end
  end

  assign cur_word = mem[pc_q];
  assign cur_mvi  = (cur_word[8:6] == OpMvi);
  // MVI in the last slot takes its immediate from address 0.
  assign imm_addr = (pc_q == 5'(DEPTH - 1)) ? 5'd0 : pc_q + 5'd1;
  assign operand  = cur_mvi ? mem[imm_addr] : cur_word;
  assign pc_sum   = {1'b0, pc_q} + (cur_mvi ? 6'd2 : 6'd1);
  assign pc_wrap  = (pc_sum >= 6'(DEPTH));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fin_d   = fin_q;
    err_d   = err_q;
    cnt_d   = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    unique case (state_q)
      StIdle: begin
        if (Start && Done) begin
          pc_d    = 5'd0;
          fin_d   = 1'b0;
          err_d   = 1'b0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = (cur_word[8:6] == OpHalt) ? StHalted : StWaitAck;
      end
      StWaitAck: begin
        if (!Done) begin
          state_d = StWaitDone;
        end else if (cnt_q == 4'(ACK_TO - 1)) begin
          state_d = StErr;
        end
      end
      StWaitDone: begin
        if (Done) begin
          state_d = StAdvance;
        end else if (cnt_q == 4'(DONE_TO - 1)) begin
          state_d = StErr;
        end
      end
      StAdvance: begin
        pc_d    = pc_sum[4:0];
        state_d = pc_wrap ? StHalted : StIssue;
      end
      StHalted: state_d = StIdle;
      StErr:    state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (state_d == StHalted) fin_d = 1'b1;
    if (state_d == StErr)    err_d = 1'b1;
    if (state_d != state_q)  cnt_d = 4'd0;
  end

  // Outputs are computed for the state being entered so the registered values line up with it.
  assign next_word = mem[pc_d];

  always_comb begin
    run_d  = 1'b0;
    din_d  = din_q;
    busy_d = (state_d == StIssue) || (state_d == StWaitAck) ||
             (state_d == StWaitDone) || (state_d == StAdvance);
    unique case (state_d)
      StIssue: begin
        if (next_word[8:6] == OpHalt) begin
          din_d = 9'd0;
        end else begin
          din_d = next_word;
          run_d = 1'b1;
        end
      end
      StWaitAck: begin
        if (state_q == StIssue) din_d = operand;
      end
      StIdle, StHalted, StErr: din_d = 9'd0;
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= StIdle;
      pc_q    <= 5'd0;
      din_q   <= 9'd0;
      run_q   <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      din_q   <= din_d;
      run_q   <= run_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign Finished = fin_q;
  assign Error    = err_q;
  assign PC       = pc_q;

endmodule
